// File: rtl/mult_fu_ctrl.sv
// ============================================================================
// Module   : mult_fu_ctrl
// Purpose  : Issue/retire controller around an external chained multiplier.
//            Optional macro MULT_CDB_BYPASS_EN forwards the pipe tail to cdb_*.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module mult_fu_ctrl #(
  parameter int NUM_STAGE = 4,
  parameter int TAG_W     = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [1:0]             issue_func,
  input  logic [`XLEN-1:0]       issue_rs1,
  input  logic [`XLEN-1:0]       issue_rs2,
  input  logic [TAG_W-1:0]       issue_tag,
  input  logic                   squash,
  output logic                   stage_start,
  output logic [2*`XLEN-1:0]     stage_mcand,
  output logic [2*`XLEN-1:0]     stage_mplier,
  input  logic                   stage_done,
  input  logic [2*`XLEN-1:0]     stage_product,
  output logic                   cdb_valid,
  input  logic                   cdb_ready,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [`XLEN-1:0]       cdb_result
);

  localparam int XW    = `XLEN;
  localparam int PTR_W = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;
  localparam int CNT_W = $clog2(NUM_STAGE + 1);
  localparam int OCC_W = $clog2(2 * NUM_STAGE + 1);
  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(NUM_STAGE - 1);

  logic                 w_accept;
  logic                 w_s1;
  logic                 w_s2;
  logic [NUM_STAGE-1:0] r_pvld;
  logic [TAG_W-1:0]     r_ptag  [NUM_STAGE];
  logic [1:0]           r_pfunc [NUM_STAGE];
  logic                 w_tail_vld;
  logic [TAG_W-1:0]     w_tail_tag;
  logic [XW-1:0]        w_sel;

  logic [TAG_W-1:0]     r_ftag [NUM_STAGE];
  logic [XW-1:0]        r_fdat [NUM_STAGE];
  logic [PTR_W-1:0]     r_wr;
  logic [PTR_W-1:0]     r_rd;
  logic [CNT_W-1:0]     r_count;
  logic                 w_fifo_vld;
  logic                 w_byp;
  logic                 w_push;
  logic                 w_pop;
  logic [OCC_W-1:0]     w_pipe_cnt;
  logic [OCC_W-1:0]     w_occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_accept = issue_valid & issue_ready;

  // MULHU zero-extends both; only MUL/MULH treat rs2 as signed.
  assign w_s1 = issue_rs1[XW-1] & (issue_func != 2'b11);
  assign w_s2 = issue_rs2[XW-1] & ~issue_func[1];

  assign stage_start  = w_accept;
  assign stage_mcand  = w_accept ? {{XW{w_s1}}, issue_rs1} : '0;
  assign stage_mplier = w_accept ? {{XW{w_s2}}, issue_rs2} : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pvld <= '0;
    end else if (squash) begin
      r_pvld <= '0;
    end else begin
      r_pvld[0] <= w_accept;
      for (int i = 1; i < NUM_STAGE; i++) r_pvld[i] <= r_pvld[i-1];
    end
  end

  always_ff @(posedge clock) begin
    r_ptag[0]  <= issue_tag;
    r_pfunc[0] <= issue_func;
    for (int i = 1; i < NUM_STAGE; i++) begin
      r_ptag[i]  <= r_ptag[i-1];
      r_pfunc[i] <= r_pfunc[i-1];
    end
  end

  assign w_tail_vld = r_pvld[NUM_STAGE-1];
  assign w_tail_tag = r_ptag[NUM_STAGE-1];
  assign w_sel      = (r_pfunc[NUM_STAGE-1] == 2'b00) ? stage_product[XW-1:0]
                                                       : stage_product[2*XW-1:XW];

  assign w_fifo_vld = (r_count != '0);

`ifdef MULT_CDB_BYPASS_EN
  assign w_byp      = w_tail_vld & ~w_fifo_vld;
  assign cdb_tag    = w_byp ? w_tail_tag : r_ftag[r_rd];
  assign cdb_result = w_byp ? w_sel      : r_fdat[r_rd];
`else
  assign w_byp      = 1'b0;
  assign cdb_tag    = r_ftag[r_rd];
  assign cdb_result = r_fdat[r_rd];
`endif

  assign cdb_valid = w_fifo_vld | w_byp;
  assign w_push    = w_tail_vld & ~squash & ~(w_byp & cdb_ready);
  assign w_pop     = w_fifo_vld & cdb_ready & ~squash;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_ftag[r_wr] <= w_tail_tag;
      r_fdat[r_wr] <= w_sel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A pop in the current cycle earns no credit, keeping total work <= FIFO depth.
  always_comb begin
    w_pipe_cnt = '0;
    for (int i = 0; i < NUM_STAGE; i++) w_pipe_cnt = w_pipe_cnt + OCC_W'(r_pvld[i]);
  end

  assign w_occ       = w_pipe_cnt + OCC_W'(r_count);
  assign issue_ready = ~reset & ~squash & (w_occ < OCC_W'(NUM_STAGE));

  a_done_agrees: assert property (@(posedge clock) disable iff (reset)
                                  w_tail_vld |-> stage_done);

endmodule

`default_nettype wire

// File: tb/tb_mult_fu_ctrl.sv
// ============================================================================
// Module   : tb_mult_fu_ctrl
// Purpose  : Directed self-checking bench for mult_fu_ctrl with a 4-stage
//            behavioural multiplier chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_fu_ctrl;

  localparam int NS = 4;
`ifdef MULT_CDB_BYPASS_EN
  localparam int LAT = NS;
`else
  localparam int LAT = NS + 1;
`endif
  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

  logic        clock, reset, squash;
  logic        issue_valid, issue_ready;
  logic [1:0]  issue_func;
  logic [31:0] issue_rs1, issue_rs2;
  logic [5:0]  issue_tag;
  logic        stage_start, stage_done;
  logic [63:0] stage_mcand, stage_mplier, stage_product;
  logic        cdb_valid, cdb_ready;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_result;

  int checks   = 0;
  int failures = 0;

  mult_fu_ctrl #(.NUM_STAGE(NS), .TAG_W(6)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_func(issue_func), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_tag(issue_tag), .squash(squash),
    .stage_start(stage_start), .stage_mcand(stage_mcand), .stage_mplier(stage_mplier),
    .stage_done(stage_done), .stage_product(stage_product),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
    .cdb_result(cdb_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier chain: not reset by the DUT reset, so in-flight work survives it.
  logic [63:0]   m_prod [NS];
  logic [NS-1:0] m_vld;
  logic          m_rst;
  always_ff @(posedge clock) begin
    if (m_rst) m_vld <= '0;
    else       m_vld <= {m_vld[NS-2:0], stage_start};
    m_prod[0] <= stage_mcand * stage_mplier;
    for (int i = 1; i < NS; i++) m_prod[i] <= m_prod[i-1];
  end
  assign stage_done    = m_vld[NS-1];
  assign stage_product = m_prod[NS-1];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t);
    issue_valid = 1'b1; issue_func = f; issue_rs1 = a; issue_rs2 = b; issue_tag = t;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_func = 2'b00; issue_rs1 = '0; issue_rs2 = '0; issue_tag = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (cdb_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, cdb_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b1; m_rst = 1'b1; squash = 1'b0; cdb_ready = 1'b1;
    idle();
    tick(); tick();
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_issue_ready", issue_ready, 1'b0);
    chk("rst_stage_start", stage_start, 1'b0);
    reset = 1'b0; m_rst = 1'b0;
    tick();

    // MUL -1*2 with exact latency
    issue(MUL, 32'hFFFF_FFFF, 32'd2, 6'd5);
    #1;
    chk("t1_ready", issue_ready, 1'b1);
    chk("t1_start", stage_start, 1'b1);
    chk("t1_mcand", stage_mcand, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_mplier", stage_mplier, 64'h2);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      idle();
      #1;
      if (k == 1) begin
        chk("t1_idle_start", stage_start, 1'b0);
        chk("t1_idle_mcand", stage_mcand, 64'h0);
      end
      chk("t1_valid_cycle", cdb_valid, (k == LAT));
    end
    chk("t1_result", cdb_result, 32'hFFFF_FFFE);
    chk("t1_tag", cdb_tag, 6'd5);
    tick();
    chk("t1_popped", cdb_valid, 1'b0);

    // high-word variants, back to back, in-order exit
    issue(MULH, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10);
    #1;
    chk("t2_mulh_mplier", stage_mplier, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    issue(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11);
    #1;
    chk("t2_mulhsu_mcand", stage_mcand, 64'hFFFF_FFFF_8000_0000);
    chk("t2_mulhsu_mplier", stage_mplier, 64'h0000_0000_FFFF_FFFF);
    tick();
    issue(MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12);
    #1;
    chk("t2_mulhu_mcand", stage_mcand, 64'h0000_0000_8000_0000);
    tick();
    idle();
    for (int k = 3; k < LAT; k++) tick();
    #1;
    chk("t2_mulh_valid", cdb_valid, 1'b1);
    chk("t2_mulh_tag", cdb_tag, 6'd10);
    chk("t2_mulh_res", cdb_result, 32'h0000_0000);
    tick();
    chk("t2_mulhsu_tag", cdb_tag, 6'd11);
    chk("t2_mulhsu_res", cdb_result, 32'h8000_0000);
    tick();
    chk("t2_mulhu_tag", cdb_tag, 6'd12);
    chk("t2_mulhu_res", cdb_result, 32'h7FFF_FFFF);
    tick();
    chk("t2_empty", cdb_valid, 1'b0);

    // back-pressure: 6 offered, 4 accepted
    cdb_ready = 1'b0;
    begin
      int acc = 0;
      for (int c = 0; c < 10; c++) begin
        if (acc < 6) issue(MUL, 32'(acc + 1), 32'd3, 6'(20 + acc));
        else         idle();
        #1;
        chk("t3_ready", issue_ready, (c < 4));
        if (issue_ready) acc++;
        tick();
      end
    end
    idle();
    #1;
    chk("t3_head_valid", cdb_valid, 1'b1);
    chk("t3_head_tag", cdb_tag, 6'd20);
    tick();
    chk("t3_hold_tag", cdb_tag, 6'd20);
    chk("t3_hold_res", cdb_result, 32'd3);
    cdb_ready = 1'b1;
    #1;
    chk("t3_pop_no_credit", issue_ready, 1'b0);
    tick();
    chk("t3_credit", issue_ready, 1'b1);
    chk("t3_tag21", cdb_tag, 6'd21);
    chk("t3_res21", cdb_result, 32'd6);
    tick();
    chk("t3_tag22", cdb_tag, 6'd22);
    chk("t3_res22", cdb_result, 32'd9);
    tick();
    chk("t3_tag23", cdb_tag, 6'd23);
    chk("t3_res23", cdb_result, 32'd12);
    tick();
    chk("t3_drained", cdb_valid, 1'b0);
    issue(MUL, 32'd5, 32'd3, 6'd24);
    tick();
    issue(MUL, 32'd6, 32'd3, 6'd25);
    tick();
    idle();
    wait_valid("t3_wait24");
    chk("t3_tag24", cdb_tag, 6'd24);
    chk("t3_res24", cdb_result, 32'd15);
    tick();
    chk("t3_tag25", cdb_tag, 6'd25);
    chk("t3_res25", cdb_result, 32'd18);
    tick();

    // squash two cycles after accept
    issue(MUL, 32'd9, 32'd9, 6'd30);
    tick();
    idle();
    tick();
    squash = 1'b1;
    issue(MUL, 32'd1, 32'd1, 6'd31);
    #1;
    chk("t4_squash_ready", issue_ready, 1'b0);
    chk("t4_squash_start", stage_start, 1'b0);
    tick();
    squash = 1'b0;
    idle();
    #1;
    chk("t4_ready_after", issue_ready, 1'b1);
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (cdb_valid) seen = 1'b1;
        tick();
      end
      chk("t4_no_result", seen, 1'b0);
    end

    // squash empties a held FIFO entry
    cdb_ready = 1'b0;
    issue(MUL, 32'd2, 32'd2, 6'd35);
    tick();
    idle();
    wait_valid("t4_fifo_wait");
    tick();
    chk("t4_fifo_held", cdb_valid, 1'b1);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    #1;
    chk("t4_fifo_flushed", cdb_valid, 1'b0);

    // asynchronous reset with work outstanding
    issue(MUL, 32'd1, 32'd4, 6'd40);
    tick();
    issue(MUL, 32'd2, 32'd4, 6'd41);
    tick();
    issue(MUL, 32'd3, 32'd4, 6'd42);
    tick();
    idle();
    tick(); tick();
    #1;
    chk("t5_pre_valid", cdb_valid, 1'b1);
    chk("t5_pre_tag", cdb_tag, 6'd40);
    issue(MUL, 32'd7, 32'd7, 6'd44);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", cdb_valid, 1'b0);
    chk("t5_rst_ready", issue_ready, 1'b0);
    chk("t5_rst_start", stage_start, 1'b0);
    tick();
    idle();
    tick();
    reset = 1'b0;
    cdb_ready = 1'b1;
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        #1;
        if (cdb_valid) seen = 1'b1;
        tick();
      end
      chk("t5_no_stale", seen, 1'b0);
    end

    // MUL 3*7 with exact latency (NS with bypass, NS+1 without)
    issue(MUL, 32'd3, 32'd7, 6'd7);
    #1;
    chk("t6_accept", stage_start, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      idle();
      #1;
      chk("t6_valid_cycle", cdb_valid, (k == LAT));
    end
    chk("t6_result", cdb_result, 32'd21);
    chk("t6_tag", cdb_tag, 6'd7);
    tick();
    chk("t6_consumed", cdb_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_fu_ctrl.md
MULT_FU_CTRL -- requirements
Module: mult_fu_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGE, default 4: number of chained multiplier stages; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter TAG_W, default 6: destination physical-register tag width.
REQ-003 SHALL take data width from the global `XLEN` (32).
REQ-004 SHALL have ports:
- clock  in  1  sole clock; rising edge
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  issue packet present
- issue_ready  out  1  controller can accept a packet
- issue_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- issue_rs1  in  XLEN  operand A
- issue_rs2  in  XLEN  operand B
- issue_tag  in  TAG_W  destination tag
- squash  in  1  flush all in-flight and queued work
- stage_start  out  1  start to the first multiplier stage
- stage_mcand  out  2*XLEN  extended operand A to the first stage
- stage_mplier  out  2*XLEN  extended operand B to the first stage
- stage_done  in  1  done from the last stage
- stage_product  in  2*XLEN  product from the last stage
- cdb_valid  out  1  result available
- cdb_ready  in  1  consumer accepts the result
- cdb_tag  out  TAG_W  result tag
- cdb_result  out  XLEN  selected result word

Function
REQ-005 SHALL define accept as issue_valid & issue_ready.
- On accept: stage_start=1 in the same cycle.
- With no accept: stage_start=0, and stage_mcand and stage_mplier are 0.
REQ-006 SHALL extend operands to 2*XLEN as follows; all other bits and funcs are zero-extended:
- rs1 sign-extended for MUL, MULH, MULHSU.
- rs2 sign-extended for MUL, MULH.
REQ-007 SHALL keep an internal NUM_STAGE-deep shift pipe of {valid, tag, func}, advancing every cycle without stalls, aligned so its last entry matches stage_product.
REQ-008 SHALL write {tag, selected result} into a NUM_STAGE-entry result FIFO at the edge where the pipe tail is valid, using the pipe valid bit only; stage_done is checked for agreement, never used for control.
REQ-009 SHALL select the result as stage_product[XLEN-1:0] for MUL and stage_product[2*XLEN-1:XLEN] for MULH, MULHSU and MULHU.
REQ-010 SHALL define occupancy as valid pipe entries plus FIFO entries.
- issue_ready = ~reset & ~squash & (occupancy < NUM_STAGE).
- A same-cycle pop gives no credit, so the FIFO never overflows.
REQ-011 SHALL drive cdb_valid, cdb_tag and cdb_result from the FIFO head; pop on cdb_valid & cdb_ready; hold the head stable while cdb_ready is 0.
REQ-012 SHALL give an accept-to-cdb_valid latency of NUM_STAGE+1 cycles on an empty FIFO with the build option of REQ-016 absent; accepted packets SHALL exit in order.
REQ-013 SHALL handle squash as follows:
- Clears all pipe valid bits and empties the FIFO at the next edge.
- cdb_valid=0 from the next cycle.
- A packet presented during squash is not accepted.
- A simultaneous FIFO write or pop is discarded.
REQ-014 SHALL handle a simultaneous FIFO push and pop by keeping the count unchanged; a push into an empty FIFO with cdb_ready=1 is visible one cycle later.

Reset
REQ-015 SHALL, on reset assertion and independent of clock:
- clear all pipe valid bits, the FIFO pointers and the FIFO count;
- drive cdb_valid=0, stage_start=0 and issue_ready=0;
- continue to discard in-flight stage results after release.
Tag and data registers need no reset.

Configuration
REQ-016 SHALL support macro MULT_CDB_BYPASS_EN.
- When defined: if the FIFO is empty and the pipe tail is valid, the result drives cdb_* combinationally in that cycle (latency NUM_STAGE). If cdb_ready=1 it is consumed without a FIFO write; otherwise it is written.
- When undefined: no bypass; behaviour as REQ-012.

Verification
REQ-017 Bench SHALL cover:
- MUL rs1=0xFFFFFFFF, rs2=2, tag 5 -> cdb_result=0xFFFFFFFE, tag 5, cdb_valid at cycle 5 (NUM_STAGE=4, no bypass).
- MULH, MULHSU, MULHU with rs1=0x80000000, rs2=0xFFFFFFFF -> 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- cdb_ready held 0 while issuing 6 back-to-back -> issue_ready falls after 4 accepts; after ready rises, the results drain in order.
- squash 2 cycles after an accept -> no cdb_valid ever for that tag; issue_ready=1 the cycle after squash.
- reset asserted mid-flight with 3 outstanding -> cdb_valid=0 immediately and no stale result after release.
- MULT_CDB_BYPASS_EN defined, cdb_ready=1 -> MUL 3*7 gives 21 with cdb_valid at cycle 4.
